// File: rtl/apb_requester.sv
// APB requester: turns single-word local commands into APB SETUP/ACCESS transfers
// to one of two completers, with wait-state support and a bounded ACCESS timeout.
module apb_requester #(
  parameter int ADDWIDTH  = 8,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic                   cmd_slv,
  input  logic [ADDWIDTH-1:0]    cmd_addr,
  input  logic [DATAWIDTH-1:0]   cmd_wdata,
  input  logic [DATAWIDTH/8-1:0] cmd_strb,
  output logic                   rsp_valid,
  output logic [DATAWIDTH-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic [1:0]             PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDWIDTH-1:0]    PADDR,
  output logic [DATAWIDTH/8-1:0] PSTRB,
  output logic [DATAWIDTH-1:0]   PWDATA,
  input  logic                   PREADY,
  input  logic [DATAWIDTH-1:0]   PRDATA
);

  localparam int STRBW = DATAWIDTH / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_t;

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [1:0]           psel_r, psel_s;
  logic                 penable_r, penable_s;
  logic                 pwrite_r, pwrite_s;
  logic [ADDWIDTH-1:0]  paddr_r, paddr_s;
  logic [STRBW-1:0]     pstrb_r, pstrb_s;
  logic [DATAWIDTH-1:0] pwdata_r, pwdata_s;
  logic                 rsp_valid_r, rsp_valid_s;
  logic [DATAWIDTH-1:0] rsp_rdata_r, rsp_rdata_s;
  logic                 rsp_err_r, rsp_err_s;
  logic                 cmd_ready_r;

  // Next-state and next-output logic; cnt_r counts ACCESS cycles starting at 1.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    psel_s      = psel_r;
    penable_s   = penable_r;
    pwrite_s    = pwrite_r;
    paddr_s     = paddr_r;
    pstrb_s     = pstrb_r;
    pwdata_s    = pwdata_r;
    rsp_valid_s = 1'b0;
    rsp_rdata_s = {DATAWIDTH{1'b0}};
    rsp_err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          state_s   = SETUP;
          psel_s    = cmd_slv ? 2'b10 : 2'b01;
          penable_s = 1'b0;
          pwrite_s  = cmd_write;
          paddr_s   = cmd_addr;
          pwdata_s  = cmd_wdata;
          pstrb_s   = cmd_write ? cmd_strb : {STRBW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        state_s   = ACCESS;
        penable_s = 1'b1;
        cnt_s     = CNT_W'(1);
      end
      ACCESS: begin
        if (PREADY) begin
          state_s     = IDLE;
          psel_s      = 2'b00;
          penable_s   = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_rdata_s = pwrite_r ? {DATAWIDTH{1'b0}} : PRDATA;
        end else if (cnt_r == CNT_W'(TIMEOUT)) begin
          state_s     = IDLE;
          psel_s      = 2'b00;
          penable_s   = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s   = IDLE;
        psel_s    = 2'b00;
        penable_s = 1'b0;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      psel_r      <= 2'b00;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= {ADDWIDTH{1'b0}};
      pstrb_r     <= {STRBW{1'b0}};
      pwdata_r    <= {DATAWIDTH{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATAWIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      psel_r      <= psel_s;
      penable_r   <= penable_s;
      pwrite_r    <= pwrite_s;
      paddr_r     <= paddr_s;
      pstrb_r     <= pstrb_s;
      pwdata_r    <= pwdata_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_err_r   <= rsp_err_s;
      cmd_ready_r <= (state_s == IDLE);
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign PSEL      = psel_r;
  assign PENABLE   = penable_r;
  assign PWRITE    = pwrite_r;
  assign PADDR     = paddr_r;
  assign PSTRB     = pstrb_r;
  assign PWDATA    = pwdata_r;

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed scenarios plus randomized
// transfers checked against a transfer-level reference model.
module tb_apb_requester;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write, cmd_slv;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    PSEL;
  logic          PENABLE, PWRITE, PREADY;
  logic [AW-1:0] PADDR;
  logic [SW-1:0] PSTRB;
  logic [DW-1:0] PWDATA, PRDATA;

  int vectors = 0;
  int miscompares = 0;

  apb_requester #(.ADDWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_slv(cmd_slv), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PSTRB(PSTRB), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  // Drive every command input with junk; used wherever the DUT must ignore them.
  task automatic scramble_cmd();
    cmd_write = 1'($urandom);
    cmd_slv   = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    cmd_strb  = SW'($urandom);
  endtask

  // One complete transfer; the model predicts ACCESS length, status and read data.
  task automatic do_transfer(input logic wr, input logic slv, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                             input int waits, input logic [DW-1:0] prdata, input string name);
    logic [1:0]    psel_e;
    logic [SW-1:0] strb_e;
    logic [DW-1:0] rdata_e;
    logic          err_e;
    int            acc_e, acc;
    bit            done;
    psel_e = slv ? 2'b10 : 2'b01;
    strb_e = wr ? strb : {SW{1'b0}};
    if (waits >= TO) begin
      acc_e = TO; err_e = 1'b1; rdata_e = {DW{1'b0}};
    end else begin
      acc_e = waits + 1; err_e = 1'b0; rdata_e = wr ? {DW{1'b0}} : prdata;
    end

    @(negedge PCLK);
    vectors++;
    if ({cmd_ready, PSEL, PENABLE} !== 4'b1000)
      $display("FAIL %s_idle: got %b, want 1000", name, {cmd_ready, PSEL, PENABLE});
    if ({cmd_ready, PSEL, PENABLE} !== 4'b1000) miscompares++;
    cmd_valid = 1'b1; cmd_write = wr; cmd_slv = slv;
    cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;

    @(negedge PCLK);
    cmd_valid = 1'b0;
    scramble_cmd();
    PREADY = 1'($urandom);
    PRDATA = $urandom;
    vectors++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA, cmd_ready} !==
        {psel_e, 1'b0, wr, addr, strb_e, wdata, 1'b0}) begin
      miscompares++;
      $display("FAIL %s_setup: got %h, want %h", name,
               {PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA, cmd_ready},
               {psel_e, 1'b0, wr, addr, strb_e, wdata, 1'b0});
    end

    acc = 0; done = 1'b0;
    while (!done && acc < TO + 2) begin
      @(negedge PCLK);
      if (rsp_valid === 1'b1) begin
        done = 1'b1;
      end else begin
        acc++;
        vectors++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA, cmd_ready} !==
            {psel_e, 1'b1, wr, addr, strb_e, wdata, 1'b0}) begin
          miscompares++;
          $display("FAIL %s_access%0d: got %h, want %h", name, acc,
                   {PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA, cmd_ready},
                   {psel_e, 1'b1, wr, addr, strb_e, wdata, 1'b0});
        end
        PREADY = (acc == waits + 1);
        PRDATA = PREADY ? prdata : $urandom;
      end
    end
    PREADY = 1'b0;

    vectors++;
    if (acc !== acc_e) begin
      miscompares++;
      $display("FAIL %s_access_len: got %0d, want %0d", name, acc, acc_e);
    end
    vectors++;
    if ({done, rsp_err, rsp_rdata, PSEL, PENABLE, cmd_ready} !==
        {1'b1, err_e, rdata_e, 2'b00, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL %s_rsp: got %h, want %h", name,
               {done, rsp_err, rsp_rdata, PSEL, PENABLE, cmd_ready},
               {1'b1, err_e, rdata_e, 2'b00, 1'b0, 1'b1});
    end
    @(negedge PCLK);
    vectors++;
    if ({rsp_valid, PSEL, PADDR, PWRITE, PWDATA, PSTRB} !== {1'b0, 2'b00, addr, wr, wdata, strb_e}) begin
      miscompares++;
      $display("FAIL %s_after: got %h, want %h", name,
               {rsp_valid, PSEL, PADDR, PWRITE, PWDATA, PSTRB}, {1'b0, 2'b00, addr, wr, wdata, strb_e});
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; PREADY = 1'b0; PRDATA = {DW{1'b0}};
    cmd_valid = 1'b1;
    scramble_cmd();
    #3;
    @(negedge PCLK);
    vectors++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA, cmd_ready, rsp_valid, rsp_err, rsp_rdata} !==
        {2'b00, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_values: got %h", {PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA,
               cmd_ready, rsp_valid, rsp_err, rsp_rdata});
    end
    cmd_valid = 1'b0;
    PRESETn = 1'b1;
  endtask

  task automatic test_write_zero_wait();
    do_transfer(1'b1, 1'b0, 8'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, "write0");
  endtask

  task automatic test_read_waits();
    do_transfer(1'b0, 1'b1, 8'h10, 32'h0, 4'hF, 4, 32'hCAFEF00D, "read4w");
  endtask

  task automatic test_partial_write();
    do_transfer(1'b1, 1'b0, 8'hFF, 32'h11223344, 4'h5, 2, 32'h0, "partial");
  endtask

  task automatic test_timeout();
    do_transfer(1'b0, 1'b1, 8'h20, 32'h0, 4'h0, TO, 32'h55AA55AA, "timeout");
    do_transfer(1'b0, 1'b0, 8'h24, 32'h0, 4'h0, TO - 1, 32'h12345678, "ready_last");
  endtask

  // cmd_valid held high for three commands: accepts land every third cycle.
  task automatic test_back_to_back();
    logic          wr_q[3];
    logic          slv_q[3];
    logic [DW-1:0] exp_rd[3];
    logic [1:0]    psel_e;
    int            k, ph;
    for (int i = 0; i < 3; i++) begin
      wr_q[i] = (i == 1);
      slv_q[i] = 1'(i);
      exp_rd[i] = {DW{1'b0}};
    end
    PREADY = 1'b1;
    @(negedge PCLK);
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) @(negedge PCLK);
      k = c / 3; ph = c % 3;
      psel_e = (ph == 0) ? 2'b00 : (slv_q[k] ? 2'b10 : 2'b01);
      vectors++;
      if ({cmd_ready, rsp_valid, PENABLE, PSEL} !== {ph == 0, ph == 0 && c > 0, ph == 2, psel_e}) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d: got %b, want %b", c, {cmd_ready, rsp_valid, PENABLE, PSEL},
                 {ph == 0, ph == 0 && c > 0, ph == 2, psel_e});
      end
      if (ph == 0 && c > 0) begin
        vectors++;
        if ({rsp_err, rsp_rdata} !== {1'b0, exp_rd[k-1]}) begin
          miscompares++;
          $display("FAIL b2b_rsp%0d: got %h, want %h", k - 1, {rsp_err, rsp_rdata}, {1'b0, exp_rd[k-1]});
        end
      end
      if (ph == 0 && k < 3) begin
        cmd_valid = 1'b1; cmd_write = wr_q[k]; cmd_slv = slv_q[k];
        cmd_addr = AW'($urandom); cmd_wdata = $urandom; cmd_strb = SW'($urandom);
      end else if (ph == 0) begin
        cmd_valid = 1'b0;
      end
      if (ph == 2) begin
        PRDATA = $urandom;
        exp_rd[k] = wr_q[k] ? {DW{1'b0}} : PRDATA;
      end
    end
    PREADY = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_slv = 1'b1;
    cmd_addr = 8'h3C; cmd_wdata = 32'hA5A5F00F; cmd_strb = 4'hC;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    PREADY = 1'b0;
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 1'b0;
    PREADY = 1'b1;
    #1;
    vectors++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA, cmd_ready, rsp_valid, rsp_err, rsp_rdata} !==
        {2'b00, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL midreset_values: got %h", {PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA,
               cmd_ready, rsp_valid, rsp_err, rsp_rdata});
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    PREADY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge PCLK);
      vectors++;
      if ({rsp_valid, cmd_ready, PSEL} !== 4'b0100) begin
        miscompares++;
        $display("FAIL midreset_norsp%0d: got %b, want 0100", i, {rsp_valid, cmd_ready, PSEL});
      end
    end
    do_transfer(1'b0, 1'b0, 8'h44, 32'h0, 4'hF, 1, 32'h0BADCAFE, "post_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      do_transfer(1'($urandom), 1'($urandom), AW'($urandom), $urandom, SW'($urandom),
                  int'($urandom_range(0, TO + 1)), $urandom, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_partial_write();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule

// File: doc/apb_requester.md
# apb_requester

APB requester (master) that turns single-word commands from a local command port into APB SETUP/ACCESS transfers to one of two APB completers. It sits between the on-chip command source and the APB completers, which share PADDR/PWRITE/PSTRB/PWDATA and have one PSEL each. It returns read data and a per-transfer completion and timeout status. One transfer is in flight at a time; completers may insert wait states through PREADY, and a bounded timeout covers a completer that never responds.

## Interface
- ADDWIDTH, 8, APB address width
- DATAWIDTH, 32, APB data width (multiple of 8)
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort (≥2)
- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  requester can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_slv  in  1  target completer index (0 or 1)
- cmd_addr  in  ADDWIDTH  transfer address
- cmd_wdata  in  DATAWIDTH  write data
- cmd_strb  in  DATAWIDTH/8  write byte strobes
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATAWIDTH  read data (0 for writes and aborts)
- rsp_err  out  1  1 = transfer aborted by timeout
- PSEL  out  2  one-hot completer select
- PENABLE  out  1  ACCESS phase
- PWRITE  out  1  transfer direction
- PADDR  out  ADDWIDTH  address
- PSTRB  out  DATAWIDTH/8  byte strobes
- PWDATA  out  DATAWIDTH  write data
- PREADY  in  1  completer ready, meaningful only in ACCESS
- PRDATA  in  DATAWIDTH  completer read data

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state IDLE.
- cmd_ready = 1 only in IDLE. A command is accepted on a rising edge where cmd_valid & cmd_ready.
- IDLE→SETUP on accept. The command is captured into PADDR, PWRITE, PWDATA, and PSTRB. PSTRB is forced to 0 for reads. PSEL[cmd_slv] = 1 and PENABLE = 0.
- SETUP→ACCESS unconditionally after one cycle. PENABLE = 1 and PSEL is held.
- ACCESS with PREADY = 1: the transfer completes at that edge.
  - State → IDLE.
  - PSEL and PENABLE → 0.
  - rsp_valid = 1 for the next cycle and rsp_err = 0.
  - rsp_rdata = PRDATA sampled at that edge for reads, 0 for writes.
- ACCESS with PREADY = 0: a wait-state counter increments. The counter is 1 in the first ACCESS cycle.
- Timeout: if PREADY is still 0 in ACCESS cycle TIMEOUT, the transfer aborts at that edge.
  - State → IDLE and PSEL/PENABLE → 0.
  - rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - PREADY = 1 in cycle TIMEOUT counts as a normal completion.
- PADDR, PWRITE, PWDATA, and PSTRB are stable from SETUP through the end of ACCESS. In IDLE they hold their last values.
- cmd_* inputs are ignored outside the accept cycle.
- PREADY and PRDATA are ignored outside ACCESS.
- Exactly one PSEL bit is high during SETUP/ACCESS; PSEL = 0 in IDLE.

## Timing
- All outputs are registered.
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PSTRB=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=1.
- Accept at edge E0. SETUP spans E0→E1 and the first ACCESS cycle spans E1→E2.
- Zero wait states: PREADY is sampled at E2, rsp_valid is high E2→E3, and cmd_ready is high again from E2.
- Throughput is one transfer per 3 cycles minimum. Per transfer this is: accept → SETUP → ACCESS → IDLE (accept again).
- Each wait state adds one cycle.
- Timeout response is asserted at edge E1+TIMEOUT.
- Reset asserted mid-transfer:
  - All outputs take their reset values immediately (asynchronous) and the FSM returns to IDLE.
  - No rsp_valid is generated for the interrupted transfer.
- rsp_valid and an accept can coincide: the accept in IDLE occurs while the previous rsp_valid is high.

## Test plan
- Write with zero wait states: slave 0, addr 0x10, wdata 0xDEADBEEF, strb 0xF.
  - Expect PSEL=01 and PENABLE=0 for one cycle, then PENABLE=1.
  - Expect PADDR/PWDATA stable throughout.
  - Expect rsp_valid one cycle after PREADY with rsp_err=0 and rsp_rdata=0.
- Read from slave 1, addr 0x10, with 4 wait states and PRDATA=0xCAFEF00D on the PREADY cycle.
  - Expect PSEL=10, PSTRB=0, and ACCESS lasting 5 cycles.
  - Expect rsp_rdata=0xCAFEF00D and rsp_err=0.
- Partial write with strb 0x5, addr 0xFF, wdata 0x11223344: expect PSTRB=0x5 and PADDR=0xFF through SETUP/ACCESS.
- Timeout with PREADY held 0 and TIMEOUT=16.
  - Expect exactly 16 ACCESS cycles, then PSEL=0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - Repeat with PREADY=1 in cycle 16: expect rsp_err=0.
- Back-to-back traffic: cmd_valid held high for 3 commands with zero wait states.
  - Expect accepts every 3 cycles, PSEL never high in IDLE, and 3 rsp_valid pulses in order.
- Reset mid-transfer: drop PRESETn during ACCESS.
  - Expect all outputs at reset values asynchronously and no rsp_valid.
  - After release, a new read completes normally.
